btn_event_ctrl: RTL

- Scheduler for the player buttons. Runs one shared sample-tick prescaler for all channels.
- Debounces N_BTN raw button lines with a per-channel stable-sample counter.
- Latches each debounced press as a pending event.
- A round-robin arbiter serialises pending events onto one valid/ready event port read by the game FSM.

---
 rtl/btn_event_ctrl_if.sv | 11 +
 rtl/btn_event_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl_if.sv
// Event handshake between the button controller (master) and the game FSM (slave).
interface btn_event_ctrl_if #(
   parameter int unsigned ID_W = 2
) ();
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic            evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_event_ctrl.sv
// Button scheduler: shared tick prescaler, per-channel debounce, press latching and
// round-robin event serialiser. Define AUTO_REPEAT_EN to add held-button auto-repeat.
module btn_event_ctrl #(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned ID_W         = 2,
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned STABLE_CNT   = 4,
   parameter int unsigned REPEAT_TICKS = 50
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] raw_in,
   output logic             tick,
   output logic [N_BTN-1:0] db_level,
   btn_event_ctrl_if.master evt
);
   localparam int unsigned PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam int unsigned CW = $clog2(STABLE_CNT + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;

   logic [PW-1:0]    presc;
   logic [N_BTN-1:0] sync1, sync2;
   logic [N_BTN-1:0] db_nxt, press, rpt_set, clr_mask, pending, pend_nxt;
   logic [CW-1:0]    cnt_q   [N_BTN];
   logic [CW-1:0]    cnt_nxt [N_BTN];
   logic [0:0]       state, state_nxt;
   logic             valid_nxt, found;
   logic [ID_W-1:0]  id_nxt, last_grant, grant_nxt, sel;

   // Shared sample-tick prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc == PW'(TICK_DIV)) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + PW'(1);
         tick  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   // Debounce: level flips after STABLE_CNT consecutive disagreeing tick samples
   always_comb begin
      db_nxt = db_level;
      for (int i = 0; i < int'(N_BTN); i++) begin
         cnt_nxt[i] = cnt_q[i];
         if (tick) begin
            if (sync2[i] == db_level[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt_q[i] + CW'(1) == CW'(STABLE_CNT)) begin
               cnt_nxt[i] = '0;
               db_nxt[i]  = ~db_level[i];
            end else begin
               cnt_nxt[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign press = db_nxt & ~db_level;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
   logic [RW-1:0] rpt_q   [N_BTN];
   logic [RW-1:0] rpt_nxt [N_BTN];

   // Held-button repeat counters restart on any debounced edge
   always_comb begin
      rpt_set = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         rpt_nxt[i] = rpt_q[i];
         if (db_nxt[i] != db_level[i]) begin
            rpt_nxt[i] = '0;
         end else if (tick && db_level[i]) begin
            if (rpt_q[i] + RW'(1) == RW'(REPEAT_TICKS)) begin
               rpt_nxt[i] = '0;
               rpt_set[i] = 1'b1;
            end else begin
               rpt_nxt[i] = rpt_q[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_BTN); i++) rpt_q[i] <= '0;
      end else begin
         rpt_q <= rpt_nxt;
      end
   end
`else
   assign rpt_set = '0;
`endif

   // A set arriving on the same edge as its clear wins
   assign pend_nxt = (pending & ~clr_mask) | press | rpt_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level <= '0;
         pending  <= '0;
         for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
      end else begin
         db_level <= db_nxt;
         pending  <= pend_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   // Round-robin pick: first pending channel after the last grant
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= int'(N_BTN); k++) begin
         idx = int'(last_grant) + k;
         if (idx >= int'(N_BTN)) idx = idx - int'(N_BTN);
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = evt.evt_valid;
      id_nxt    = evt.evt_id;
      grant_nxt = last_grant;
      clr_mask  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               id_nxt    = sel;
               valid_nxt = 1'b1;
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (evt.evt_ready) begin
               clr_mask[evt.evt_id] = 1'b1;
               grant_nxt            = evt.evt_id;
               valid_nxt            = 1'b0;
               state_nxt            = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         evt.evt_valid <= 1'b0;
         evt.evt_id    <= '0;
         last_grant    <= ID_W'(N_BTN - 1);
      end else begin
         state         <= state_nxt;
         evt.evt_valid <= valid_nxt;
         evt.evt_id    <= id_nxt;
         last_grant    <= grant_nxt;
      end
   end
endmodule
